// File: rtl/gate_share_arbiter_if.sv
// Request/grant/result bundle between N requesters and the shared gate arbiter.
// master = requester side, slave = arbiter side.
interface gate_share_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [N-1:0]   a_in;
  logic [N-1:0]   b_in;
  logic [2*N-1:0] op_in;
  logic [N-1:0]   gnt;
  logic           y_out;
  logic           valid_out;
  logic           busy;

  modport master (
    output req, a_in, b_in, op_in,
    input  gnt, y_out, valid_out, busy
  );

  modport slave (
    input  req, a_in, b_in, op_in,
    output gnt, y_out, valid_out, busy
  );
endinterface

// File: rtl/gate_share_arbiter.sv
// Shares one registered AND/OR/XOR/NAND unit among N requesters; round-robin, or fixed priority with GATE_ARB_FIXED_PRIO_EN.
// Latency: gnt one edge after req is sampled, y_out/valid_out one edge later; one slot every 3 cycles.
// Backpressure: no queueing; req is only sampled while idle, so a requester holds req until it sees gnt.
module gate_share_arbiter #(
  parameter int N  = 4,
  parameter int PW = 3
) (
  input  logic               clk,
  input  logic               rst,
  gate_share_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  gnt_q;
  logic          y_q;
  logic          vld_q;
  logic          busy_q;
  logic          cap_a;
  logic          cap_b;
  logic [1:0]    cap_op;

  logic          found;
  logic [PW-1:0] win;
  logic [PW:0]   cand;
  logic [N-1:0]  gnt_nxt;
  logic          sel_a;
  logic          sel_b;
  logic [1:0]    sel_op;
  logic          gate_res;

`ifndef GATE_ARB_FIXED_PRIO_EN
  logic [PW-1:0] ptr;
  logic [PW:0]   win_inc;
`endif

  // Winner search: candidate k is the k-th requester visited from the search start.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
`ifdef GATE_ARB_FIXED_PRIO_EN
      cand = (PW+1)'(k);
`else
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(N)) begin
        cand = cand - (PW+1)'(N);
      end
`endif
      for (int i = 0; i < N; i++) begin
        if (!found && cand == (PW+1)'(i) && bus.req[i]) begin
          found = 1'b1;
          win   = PW'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_nxt = '0;
    sel_a   = 1'b0;
    sel_b   = 1'b0;
    sel_op  = 2'b00;
    for (int i = 0; i < N; i++) begin
      if (win == PW'(i)) begin
        gnt_nxt[i] = 1'b1;
        sel_a      = bus.a_in[i];
        sel_b      = bus.b_in[i];
        sel_op     = bus.op_in[2*i +: 2];
      end
    end
  end

  always_comb begin
    gate_res = 1'b0;
    case (cap_op)
      2'b00:   gate_res = cap_a & cap_b;
      2'b01:   gate_res = cap_a | cap_b;
      2'b10:   gate_res = cap_a ^ cap_b;
      default: gate_res = ~(cap_a & cap_b);
    endcase
  end

`ifndef GATE_ARB_FIXED_PRIO_EN
  assign win_inc = {1'b0, win} + (PW+1)'(1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt_q  <= '0;
      y_q    <= 1'b0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
      cap_a  <= 1'b0;
      cap_b  <= 1'b0;
      cap_op <= 2'b00;
`ifndef GATE_ARB_FIXED_PRIO_EN
      ptr    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          gnt_q  <= '0;
          vld_q  <= 1'b0;
          busy_q <= 1'b0;
          if (found) begin
            gnt_q  <= gnt_nxt;
            cap_a  <= sel_a;
            cap_b  <= sel_b;
            cap_op <= sel_op;
            busy_q <= 1'b1;
            state  <= BUSY;
`ifndef GATE_ARB_FIXED_PRIO_EN
            ptr    <= (win_inc == (PW+1)'(N)) ? '0 : win_inc[PW-1:0];
`endif
          end
        end
        BUSY: begin
          y_q   <= gate_res;
          vld_q <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          // y_q is left alone so the last result stays visible.
          gnt_q  <= '0;
          vld_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          gnt_q  <= '0;
          vld_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.y_out     = y_q;
  assign bus.valid_out = vld_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_gate_share_arbiter.sv
// Bench for gate_share_arbiter: slot-age reference model checked every cycle plus directed literal checks.
module tb_gate_share_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;

  gate_share_arbiter_if #(.N(N)) bus ();

  gate_share_arbiter #(.N(N), .PW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic gate_fn(input logic [1:0] op, input logic a, input logic b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Reference model: a slot is tracked by its age in cycles since the grant edge.
  int   m_age = -1;
  int   m_ptr = 0;
  int   m_g   = 0;
  int   m_w;
  logic m_y   = 1'b0;
  logic m_res = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_age = -1;
      m_ptr = 0;
      m_y   = 1'b0;
    end else if (m_age == 0) begin
      m_age = 1;
      m_y   = m_res;
    end else if (m_age == 1) begin
      m_age = 2;
    end else begin
      m_w = -1;
      for (int k = 0; k < N; k++) begin
`ifdef GATE_ARB_FIXED_PRIO_EN
        if (m_w < 0 && bus.req[k]) m_w = k;
`else
        if (m_w < 0 && bus.req[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
`endif
      end
      if (m_w >= 0) begin
        m_age = 0;
        m_g   = m_w;
        m_res = gate_fn(bus.op_in[2*m_w +: 2], bus.a_in[m_w], bus.b_in[m_w]);
        m_ptr = (m_w + 1) % N;
      end else begin
        m_age = -1;
      end
    end
  end

  initial begin
    @(negedge clk);
    forever begin
      chk("model_gnt",   int'(bus.gnt),       (m_age == 0 || m_age == 1) ? (1 << m_g) : 0);
      chk("model_valid", int'(bus.valid_out), (m_age == 1) ? 1 : 0);
      chk("model_busy",  int'(bus.busy),      (m_age == 0 || m_age == 1) ? 1 : 0);
      chk("model_y",     int'(bus.y_out),     int'(m_y));
      @(negedge clk);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.valid_out || bus.gnt != '0) && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk("wait_idle_timeout", n, 0);
  endtask

  logic [1:0] sweep_op [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  int         sweep_y  [4] = '{1, 1, 0, 0};

  task automatic collect(input int cycles, output int gl [$], output int pulses, output int gaps_bad);
    logic [N-1:0] prev = '0;
    int last = -100;
    gl = {};
    pulses = 0;
    gaps_bad = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.gnt != '0 && prev == '0) gl.push_back(onehot_idx(bus.gnt));
      if (bus.valid_out) begin
        if (pulses > 0 && c - last != 3) gaps_bad++;
        last = c;
        pulses++;
      end
      prev = bus.gnt;
    end
  endtask

  int glist [$];
  int npulse;
  int ngap;
  int n3;
  int extra;

  initial begin
    rst = 1'b1;
    bus.req = '1;
    bus.a_in = '0;
    bus.b_in = '0;
    bus.op_in = '0;

    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt",   int'(bus.gnt), 0);
      chk("rst_busy",  int'(bus.busy), 0);
      chk("rst_valid", int'(bus.valid_out), 0);
      chk("rst_y",     int'(bus.y_out), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("first_gnt_after_rst", int'(bus.gnt), 1);
    bus.req = '0;
    wait_idle();

    // Single OR on requester 2
    bus.req = 4'b0100; bus.a_in = 4'b0100; bus.b_in = 4'b0000; bus.op_in = 8'b00_01_00_00;
    @(negedge clk);
    chk("single_gnt", int'(bus.gnt), 4);
    bus.req = '0;
    @(negedge clk);
    chk("single_y",     int'(bus.y_out), 1);
    chk("single_valid", int'(bus.valid_out), 1);
    @(negedge clk);
    chk("single_gnt_low",  int'(bus.gnt), 0);
    chk("single_busy_low", int'(bus.busy), 0);

    // Opcode sweep on requester 1 with operands (1,1)
    bus.a_in = 4'b0010; bus.b_in = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      bus.op_in = {4'b0000, sweep_op[i], 2'b00};
      bus.req = 4'b0010;
      @(negedge clk);
      chk("sweep_gnt", int'(bus.gnt), 2);
      bus.req = '0;
      @(negedge clk);
      chk("sweep_y", int'(bus.y_out), sweep_y[i]);
      chk("sweep_valid", int'(bus.valid_out), 1);
      @(negedge clk);
    end

    // Round-robin with all requesting, starting from a fresh pointer
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req = '1;
    collect(12, glist, npulse, ngap);
    bus.req = '0;
    chk("rr_pulses", npulse, 4);
    chk("rr_gap", ngap, 0);
    chk("rr_ngrants", glist.size(), 4);
    for (int k = 0; k < glist.size(); k++) begin
`ifdef GATE_ARB_FIXED_PRIO_EN
      chk("rr_order", glist[k], 0);
`else
      chk("rr_order", glist[k], k);
`endif
    end
    wait_idle();

    // Operand capture: req and a_in change during BUSY
    bus.req = 4'b1000; bus.a_in = 4'b1000; bus.b_in = 4'b1000; bus.op_in = 8'b00_00_00_00;
    @(negedge clk);
    chk("cap_gnt", int'(bus.gnt), 8);
    bus.req = '0; bus.a_in = '0;
    @(negedge clk);
    chk("cap_y", int'(bus.y_out), 1);
    chk("cap_valid", int'(bus.valid_out), 1);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.valid_out) extra++;
    end
    chk("cap_extra_pulses", extra, 0);

    // Two contenders 0 and 3 held continuously
    bus.req = 4'b1001;
    collect(12, glist, npulse, ngap);
    bus.req = '0;
    chk("pair_ngrants", glist.size(), 4);
    n3 = 0;
    for (int k = 0; k < glist.size(); k++) begin
      if (glist[k] == 3) n3++;
`ifdef GATE_ARB_FIXED_PRIO_EN
      chk("pair_order", glist[k], 0);
`else
      chk("pair_order", glist[k], (k % 2 == 0) ? 0 : 3);
`endif
    end
`ifdef GATE_ARB_FIXED_PRIO_EN
    chk("pair_req3_grants", n3, 0);
`else
    chk("pair_req3_grants", n3, 2);
`endif
    wait_idle();

    // Reset in the middle of a slot suppresses the result pulse
    bus.req = 4'b0001; bus.a_in = 4'b0001; bus.b_in = 4'b0001; bus.op_in = 8'b00_00_00_01;
    @(negedge clk);
    chk("mid_gnt", int'(bus.gnt), 1);
    bus.req = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_valid", int'(bus.valid_out), 0);
    chk("mid_gnt_clr", int'(bus.gnt), 0);
    chk("mid_y", int'(bus.y_out), 0);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mid_after_valid", int'(bus.valid_out), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
